// File: rtl/riscv8_pkg.sv
// Shared constants and types for the 8-bit RISC datapath (register file, ALU, decoder).
package riscv8_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 2;
  localparam int NUM_REGS = 4;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_file_if.sv
// Register-file access bundle: two read ports and one write port.
// The master side (decode/writeback) drives addresses and write data; the slave returns operands.
interface reg_file_if;
  import riscv8_pkg::*;

  reg_addr_t src1;
  reg_addr_t src2;
  reg_addr_t dst;
  reg_data_t ip;
  logic      we;
  reg_data_t op1;
  reg_data_t op2;

  modport master (output src1, output src2, output dst, output ip, output we,
                  input op1, input op2);
  modport slave  (input src1, input src2, input dst, input ip, input we,
                  output op1, output op2);
endinterface

// File: rtl/reg_file_rd_port.sv
// One combinational read port: 4:1 mux over the storage array.
// With REG_FILE_BYPASS_EN defined, a same-cycle write to the addressed register
// is forwarded straight to the output ahead of the storage update.
module reg_file_rd_port #(
  parameter int DATA_W = riscv8_pkg::DATA_W,
  parameter int ADDR_W = riscv8_pkg::ADDR_W
) (
  input  logic [2**ADDR_W-1:0][DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]                src,
`ifdef REG_FILE_BYPASS_EN
  input  logic [ADDR_W-1:0]                dst,
  input  logic [DATA_W-1:0]                ip,
  input  logic                             fwd_en,
`endif
  output logic [DATA_W-1:0]                op
);
  import riscv8_pkg::*;

  // Select the addressed register, or the in-flight write data when it targets it.
  always_comb begin
    op = regs[src];
`ifdef REG_FILE_BYPASS_EN
    if (fwd_en && (src == dst)) begin
      op = ip;
    end
`endif
  end

endmodule

// File: rtl/reg_file.sv
// Four-entry, 8-bit register file: two combinational read ports, one synchronous
// write port, synchronous active-low reset clearing all entries.
// Optional write-through forwarding is enabled by defining REG_FILE_BYPASS_EN.
module reg_file #(
  parameter int DATA_W = riscv8_pkg::DATA_W,
  parameter int ADDR_W = riscv8_pkg::ADDR_W
) (
  input  logic       clk,
  input  logic       rst,
  reg_file_if.slave  bus
);
  import riscv8_pkg::*;

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] regs;

  // Reset wins over write; R0 is an ordinary writable register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      regs <= '0;
    end else if (bus.we) begin
      regs[bus.dst] <= bus.ip;
    end
  end

`ifdef REG_FILE_BYPASS_EN
  // Forwarding only applies when the write would actually land at the next edge.
  logic fwd_en;
  assign fwd_en = bus.we & rst;
`endif

  reg_file_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
    .regs   (regs),
    .src    (bus.src1),
`ifdef REG_FILE_BYPASS_EN
    .dst    (bus.dst),
    .ip     (bus.ip),
    .fwd_en (fwd_en),
`endif
    .op     (bus.op1)
  );

  reg_file_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
    .regs   (regs),
    .src    (bus.src2),
`ifdef REG_FILE_BYPASS_EN
    .dst    (bus.dst),
    .ip     (bus.ip),
    .fwd_en (fwd_en),
`endif
    .op     (bus.op2)
  );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus a randomized run
// against a plain array model of the four registers.
module tb_reg_file;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [7:0] mdl [4];

  reg_file_if bus ();

  reg_file dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // Expected read value given the current inputs and model contents.
  function automatic logic [7:0] exp_rd(input logic [1:0] a);
    if (BYPASS && bus.we && rst && (a == bus.dst)) return bus.ip;
    return mdl[a];
  endfunction

  // Advance one clock edge, update the model with what the edge should do, settle.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 4; i++) mdl[i] = 8'd0;
    end else if (bus.we) begin
      mdl[bus.dst] = bus.ip;
    end
    #1;
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
    bus.we = 1'b1; bus.dst = a; bus.ip = d;
    tick();
    bus.we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.we = 1'b0; bus.dst = '0; bus.ip = '0;
    bus.src1 = '0; bus.src2 = '0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) write_reg(2'(i), 8'($urandom_range(1, 255)));
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.src1 = 2'(i); bus.src2 = 2'(3 - i);
      #1;
      checks++;
      if (bus.op1 !== 8'd0 || bus.op2 !== 8'd0) begin
        errors++;
        $display("FAIL reset_clear addr=%0d op1=%0d op2=%0d expected 0 0", i, bus.op1, bus.op2);
      end
    end
  endtask

  task automatic test_seq_write();
    write_reg(2'd0, 8'd11);
    write_reg(2'd1, 8'd21);
    write_reg(2'd2, 8'd31);
    write_reg(2'd3, 8'd41);
    bus.src1 = 2'd2; bus.src2 = 2'd3; #1;
    checks++;
    if (bus.op1 !== 8'd31 || bus.op2 !== 8'd41) begin
      errors++;
      $display("FAIL seq_write_23 op1=%0d op2=%0d expected 31 41", bus.op1, bus.op2);
    end
    bus.src1 = 2'd0; bus.src2 = 2'd1; #1;
    checks++;
    if (bus.op1 !== 8'd11 || bus.op2 !== 8'd21) begin
      errors++;
      $display("FAIL seq_write_01 op1=%0d op2=%0d expected 11 21", bus.op1, bus.op2);
    end
  endtask

  task automatic test_write_disable();
    bus.we = 1'b0; bus.dst = 2'd1; bus.ip = 8'd99;
    repeat (3) tick();
    bus.src1 = 2'd1; #1;
    checks++;
    if (bus.op1 !== 8'd21) begin
      errors++;
      $display("FAIL write_disable op1=%0d expected 21", bus.op1);
    end
  endtask

  task automatic test_same_addr();
    bus.src1 = 2'd3; bus.dst = 2'd3; bus.ip = 8'd55; bus.we = 1'b1;
    #1;
    checks++;
    if (bus.op1 !== (BYPASS ? 8'd55 : 8'd41)) begin
      errors++;
      $display("FAIL same_addr_pre op1=%0d expected %0d", bus.op1, BYPASS ? 55 : 41);
    end
    tick();
    bus.we = 1'b0;
    #1;
    checks++;
    if (bus.op1 !== 8'd55) begin
      errors++;
      $display("FAIL same_addr_post op1=%0d expected 55", bus.op1);
    end
  endtask

  task automatic test_same_port();
    bus.src1 = 2'd0; bus.src2 = 2'd0; #1;
    checks++;
    if (bus.op1 !== 8'd11 || bus.op2 !== 8'd11) begin
      errors++;
      $display("FAIL same_port op1=%0d op2=%0d expected 11 11", bus.op1, bus.op2);
    end
  endtask

  task automatic test_reset_priority();
    rst = 1'b0; bus.we = 1'b1; bus.dst = 2'd2; bus.ip = 8'd77;
    tick();
    rst = 1'b1; bus.we = 1'b0;
    bus.src1 = 2'd2; #1;
    checks++;
    if (bus.op1 !== 8'd0) begin
      errors++;
      $display("FAIL reset_priority R2=%0d expected 0", bus.op1);
    end
    write_reg(2'd0, 8'd11);
    rst = 1'b0; bus.we = 1'b1; bus.dst = 2'd1; bus.ip = 8'd21;
    tick();
    rst = 1'b1; bus.we = 1'b0;
    bus.src1 = 2'd0; bus.src2 = 2'd1; #1;
    checks++;
    if (bus.op1 !== 8'd0 || bus.op2 !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid_seq R0=%0d R1=%0d expected 0 0", bus.op1, bus.op2);
    end
    write_reg(2'd1, 8'd21);
    bus.src2 = 2'd1; #1;
    checks++;
    if (bus.op2 !== 8'd21) begin
      errors++;
      $display("FAIL first_write_after_reset R1=%0d expected 21", bus.op2);
    end
  endtask

  task automatic test_random();
    logic [7:0] e1, e2;
    for (int n = 0; n < 300; n++) begin
      rst      = ($urandom_range(0, 15) != 0);
      bus.we   = 1'($urandom_range(0, 1));
      bus.dst  = 2'($urandom_range(0, 3));
      bus.ip   = 8'($urandom);
      bus.src1 = 2'($urandom_range(0, 3));
      bus.src2 = 2'($urandom_range(0, 3));
      #1;
      e1 = exp_rd(bus.src1);
      e2 = exp_rd(bus.src2);
      checks++;
      if (bus.op1 !== e1 || bus.op2 !== e2) begin
        errors++;
        $display("FAIL random n=%0d op1=%0d op2=%0d expected %0d %0d", n, bus.op1, bus.op2, e1, e2);
      end
      tick();
    end
    rst = 1'b1; bus.we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.src1 = 2'(i); #1;
      checks++;
      if (bus.op1 !== mdl[i]) begin
        errors++;
        $display("FAIL random_final R%0d=%0d expected %0d", i, bus.op1, mdl[i]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.we = 1'b0; bus.dst = '0; bus.ip = '0; bus.src1 = '0; bus.src2 = '0;
    for (int i = 0; i < 4; i++) mdl[i] = 8'd0;
    test_reset();
    test_seq_write();
    test_write_disable();
    test_same_addr();
    test_same_port();
    test_reset_priority();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
